// File: rtl/mac_pkg.sv
// Shared types, default widths and the accumulator add helper for the
// MAC resolve/accumulate block.
package mac_pkg;

   localparam int ROW_W  = 17;
   localparam int PROD_W = 16;
   localparam int ACC_W  = 24;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FLUSH = 2'd1,
      OUT   = 2'd2
   } state_e;

   typedef struct packed {
      logic [ACC_W-1:0] sum;
      logic             ovf;
   } add_res_t;

   // Overflow is signed overflow when is_signed, otherwise carry-out.
   // When do_sat is set, an overflowing sum clamps toward the operand sign.
   function automatic add_res_t sat_add(input logic [ACC_W-1:0] a,
                                        input logic [ACC_W-1:0] b,
                                        input logic             is_signed,
                                        input logic             do_sat);
      logic [ACC_W:0] full;
      add_res_t       r;
      full  = {1'b0, a} + {1'b0, b};
      r.sum = full[ACC_W-1:0];
      if (is_signed)
         r.ovf = (a[ACC_W-1] == b[ACC_W-1]) && (full[ACC_W-1] != a[ACC_W-1]);
      else
         r.ovf = full[ACC_W];
      if (do_sat && r.ovf) begin
         if (!is_signed)
            r.sum = '1;
         else if (a[ACC_W-1])
            r.sum = {1'b1, {(ACC_W-1){1'b0}}};
         else
            r.sum = {1'b0, {(ACC_W-1){1'b1}}};
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_resolve_accumulator_row_resolver.sv
// Stage 1: carry-propagate add of the sum/carry rows, keeping the low
// PROD_W bits of the product together with its valid and last flags.
module row_resolver
   import mac_pkg::*;
#(
   parameter int ROW_W  = mac_pkg::ROW_W,
   parameter int PROD_W = mac_pkg::PROD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              last_i,
   input  logic [ROW_W-1:0]  row_sum_i,
   input  logic [ROW_W-1:0]  row_carry_i,
   output logic              valid_o,
   output logic              last_o,
   output logic [PROD_W-1:0] prod_o
);

   logic              valid_q;
   logic              last_q;
   logic [PROD_W-1:0] prod_q;
   logic [PROD_W-1:0] prod_d;

   // The add wraps mod 2^ROW_W; only the low PROD_W bits are meaningful.
   assign prod_d = PROD_W'(row_sum_i + row_carry_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_i;
         last_q  <= valid_i & last_i;
      end
      if (valid_i)
         prod_q <= prod_d;
   end

   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign prod_o  = prod_q;

endmodule

// File: rtl/mac_resolve_accumulator.sv
// Resolves Dadda sum/carry rows into products and accumulates a stream of
// them, presenting each finished accumulation on a valid/ready port.
module mac_resolve_accumulator
   import mac_pkg::*;
#(
   parameter int ROW_W  = mac_pkg::ROW_W,
   parameter int PROD_W = mac_pkg::PROD_W,
   parameter int ACC_W  = mac_pkg::ACC_W,   // must equal mac_pkg::ACC_W (sat_add width)
   parameter int CNT_W  = 8,
   parameter bit SIGNED = 1'b1,
   parameter bit SAT    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [ROW_W-1:0] row_sum,
   input  logic [ROW_W-1:0] row_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] term_cnt,
   output logic             ovf,
   output state_e           dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // the sender holds its payload stable while valid is high and ready low.

   state_e            state_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  acc_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              ovf_q;
   logic              ovf_d;
   logic              accept;
   logic              st_valid;
   logic              st_last;
   logic [PROD_W-1:0] st_prod;
   logic [ACC_W-1:0]  prod_ext;
   add_res_t          add_res;

   assign accept = in_valid && in_ready_q;

   row_resolver #(
      .ROW_W  (ROW_W),
      .PROD_W (PROD_W)
   ) u_row_resolver (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (accept),
      .last_i      (in_last),
      .row_sum_i   (row_sum),
      .row_carry_i (row_carry),
      .valid_o     (st_valid),
      .last_o      (st_last),
      .prod_o      (st_prod)
   );

   always_comb begin
      prod_ext = SIGNED ? {{(ACC_W-PROD_W){st_prod[PROD_W-1]}}, st_prod}
                        : {{(ACC_W-PROD_W){1'b0}}, st_prod};
      add_res  = sat_add(acc_q, prod_ext, SIGNED, SAT);
      acc_d    = add_res.sum;
      ovf_d    = ovf_q | add_res.ovf;
      cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   end

   // The OUT-state clear follows the stage-2 update so it takes precedence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         if (st_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
         end
         case (state_q)
            ACCUM: begin
               if (accept && in_last) begin
                  state_q    <= FLUSH;
                  in_ready_q <= 1'b0;
               end
            end
            FLUSH: begin
               if (st_valid && st_last) begin
                  state_q     <= OUT;
                  out_valid_q <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_q     <= ACCUM;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  ovf_q       <= 1'b0;
               end
            end
            default: begin
               state_q     <= ACCUM;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign acc_out   = acc_q;
   assign term_cnt  = cnt_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_resolve_accumulator.sv
// Directed bench: three instances (unsigned+sat, signed+sat, signed+wrap)
// share one stimulus stream and are checked against hand-computed values.
module tb_mac_resolve_accumulator;
   import mac_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic [16:0] row_sum;
   logic [16:0] row_carry;
   logic        out_ready;

   logic [2:0]  in_ready_w;
   logic [2:0]  out_valid_w;
   logic [2:0]  ovf_w;
   logic [23:0] acc_w [3];
   logic [7:0]  cnt_w [3];
   state_e      st_w  [3];

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   mac_resolve_accumulator #(.SIGNED(1'b0), .SAT(1'b1)) u_uns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_last(in_last), .row_sum(row_sum), .row_carry(row_carry),
      .out_valid(out_valid_w[0]), .out_ready(out_ready), .acc_out(acc_w[0]),
      .term_cnt(cnt_w[0]), .ovf(ovf_w[0]), .dbg_state(st_w[0])
   );

   mac_resolve_accumulator #(.SIGNED(1'b1), .SAT(1'b1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_last(in_last), .row_sum(row_sum), .row_carry(row_carry),
      .out_valid(out_valid_w[1]), .out_ready(out_ready), .acc_out(acc_w[1]),
      .term_cnt(cnt_w[1]), .ovf(ovf_w[1]), .dbg_state(st_w[1])
   );

   mac_resolve_accumulator #(.SIGNED(1'b1), .SAT(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_last(in_last), .row_sum(row_sum), .row_carry(row_carry),
      .out_valid(out_valid_w[2]), .out_ready(out_ready), .acc_out(acc_w[2]),
      .term_cnt(cnt_w[2]), .ovf(ovf_w[2]), .dbg_state(st_w[2])
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [16:0] s,
                        input logic [16:0] c, input logic l);
      in_valid  = v;
      row_sum   = s;
      row_carry = c;
      in_last   = l;
   endtask

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_acc(input string tag, input logic [23:0] e0,
                                input logic [23:0] e1, input logic [23:0] e2);
      check({tag, "_acc_uns"},  32'(acc_w[0]), 32'(e0));
      check({tag, "_acc_sat"},  32'(acc_w[1]), 32'(e1));
      check({tag, "_acc_wrap"}, 32'(acc_w[2]), 32'(e2));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      tick();
      tick();

      check("rst_in_ready",  32'(in_ready_w),  32'h7);
      check("rst_out_valid", 32'(out_valid_w), 32'h0);
      check("rst_ovf",       32'(ovf_w),       32'h0);
      check_all_acc("rst", 24'h0, 24'h0, 24'h0);
      check("rst_cnt",       32'(cnt_w[1]),    32'h0);
      check("rst_state",     32'(st_w[0]),     32'(ACCUM));
      rst = 1'b0;
      tick();

      // Basic resolve: 0x100 + 0x023
      drive(1'b1, 17'h00100, 17'h00023, 1'b1);
      tick();
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      check("basic_t1_out_valid", 32'(out_valid_w), 32'h0);
      check("basic_t1_in_ready",  32'(in_ready_w),  32'h0);
      check("basic_t1_state",     32'(st_w[0]),     32'(FLUSH));
      tick();
      check("basic_out_valid", 32'(out_valid_w), 32'h7);
      check("basic_state",     32'(st_w[0]),     32'(OUT));
      check_all_acc("basic", 24'h000123, 24'h000123, 24'h000123);
      check("basic_cnt", 32'(cnt_w[0]), 32'h1);
      check("basic_ovf", 32'(ovf_w),    32'h0);
      tick();
      check("basic_hs_out_valid", 32'(out_valid_w), 32'h0);
      check("basic_hs_in_ready",  32'(in_ready_w),  32'h7);
      check_all_acc("basic_hs", 24'h0, 24'h0, 24'h0);

      // Signed product: 0x0FFF0 + 0x1000A -> 0xFFFA
      drive(1'b1, 17'h0FFF0, 17'h1000A, 1'b1);
      tick();
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      tick();
      check("signed_out_valid", 32'(out_valid_w), 32'h7);
      check_all_acc("signed", 24'h00FFFA, 24'hFFFFFA, 24'hFFFFFA);
      check("signed_ovf", 32'(ovf_w), 32'h0);
      tick();

      // Back-to-back products 1,2,3,4 (splits exercise the mod-2^17 wrap)
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1'b1, 17'h00000, 17'h00001, 1'b0);
            1: drive(1'b1, 17'h1FFFF, 17'h00003, 1'b0);
            2: drive(1'b1, 17'h00002, 17'h00001, 1'b0);
            default: drive(1'b1, 17'h10000, 17'h10004, 1'b1);
         endcase
         check($sformatf("b2b_in_ready_%0d", i), 32'(in_ready_w), 32'h7);
         tick();
      end
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      check("b2b_t1_out_valid", 32'(out_valid_w), 32'h0);
      tick();
      check("b2b_out_valid", 32'(out_valid_w), 32'h7);
      check_all_acc("b2b", 24'h00000A, 24'h00000A, 24'h00000A);
      check("b2b_cnt", 32'(cnt_w[2]), 32'h4);
      tick();
      check_all_acc("b2b_hs", 24'h0, 24'h0, 24'h0);
      check("b2b_hs_cnt", 32'(cnt_w[2]), 32'h0);

      // Saturation / wrap: 513 beats of 0x4000
      for (int i = 0; i < 513; i++) begin
         drive(1'b1, 17'h03000, 17'h01000, (i == 512));
         tick();
      end
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      tick();
      check("sat_out_valid", 32'(out_valid_w), 32'h7);
      check_all_acc("sat", 24'h804000, 24'h7FFFFF, 24'h804000);
      check("sat_ovf", 32'(ovf_w), 32'h6);
      check("sat_cnt", 32'(cnt_w[1]), 32'hFF);
      tick();
      check("sat_hs_ovf", 32'(ovf_w), 32'h0);

      // Backpressure: result held while out_ready=0, extra beat ignored
      out_ready = 1'b0;
      drive(1'b1, 17'h00070, 17'h00007, 1'b1);
      tick();
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      tick();
      drive(1'b1, 17'h00001, 17'h00000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_out_valid_%0d", i), 32'(out_valid_w), 32'h7);
         check($sformatf("bp_in_ready_%0d", i),  32'(in_ready_w),  32'h0);
         check($sformatf("bp_acc_%0d", i),       32'(acc_w[0]),    32'h77);
         check($sformatf("bp_cnt_%0d", i),       32'(cnt_w[0]),    32'h1);
         tick();
      end
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      out_ready = 1'b1;
      tick();
      check("bp_hs_out_valid", 32'(out_valid_w), 32'h0);
      check("bp_hs_in_ready",  32'(in_ready_w),  32'h7);
      check("bp_hs_cnt",       32'(cnt_w[0]),    32'h0);
      tick();
      check("bp_idle_acc", 32'(acc_w[0]), 32'h0);

      // Reset mid-accumulation after 2 of 3 beats
      drive(1'b1, 17'h00007, 17'h00000, 1'b0);
      tick();
      tick();
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_in_ready",  32'(in_ready_w),  32'h7);
      check("mid_rst_out_valid", 32'(out_valid_w), 32'h0);
      check_all_acc("mid_rst", 24'h0, 24'h0, 24'h0);
      tick();
      check("mid_rst_drain_acc", 32'(acc_w[1]), 32'h0);
      check("mid_rst_drain_cnt", 32'(cnt_w[1]), 32'h0);
      drive(1'b1, 17'h1FFFF, 17'h00006, 1'b1);
      tick();
      drive(1'b0, 17'h0, 17'h0, 1'b0);
      tick();
      check("fresh_out_valid", 32'(out_valid_w), 32'h7);
      check_all_acc("fresh", 24'h000005, 24'h000005, 24'h000005);
      check("fresh_cnt", 32'(cnt_w[0]), 32'h1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
